// File: rtl/axil_cmd_master_if.sv
// AXI-Lite bus bundle shared by the command master and its slave.
// Master drives aw/w/ar/bready/rready; slave drives the rest.
interface AXIL_IF #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_cmd_master.sv
// One-at-a-time command port to AXI-Lite master, single-cycle response pulse.
// Optional wait timeout: define AXIL_CMD_MASTER_TIMEOUT_EN.
module axil_cmd_master #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    AXIL_IF.master                axil_if
);

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RESP
    } state_t;

    state_t state;
    logic   wr_q;
    logic   aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic   adv;
    logic   tmo;
    logic   tmo_fire;

    assign aw_hs = axil_if.awvalid & axil_if.awready;
    assign w_hs  = axil_if.wvalid & axil_if.wready;
    assign b_hs  = axil_if.bvalid & axil_if.bready;
    assign ar_hs = axil_if.arvalid & axil_if.arready;
    assign r_hs  = axil_if.rvalid & axil_if.rready;

    assign axil_if.awprot = 3'b000;
    assign axil_if.arprot = 3'b000;

    // Normal progress this cycle; a real handshake wins over a coincident timeout.
    always_comb begin
        adv = 1'b0;
        unique case (state)
            WR_AW_W: adv = (aw_hs | ~axil_if.awvalid) & (w_hs | ~axil_if.wvalid);
            WR_B:    adv = b_hs;
            RD_AR:   adv = ar_hs;
            RD_R:    adv = r_hs;
            default: adv = 1'b0;
        endcase
    end

    assign tmo_fire = tmo & ~adv;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_eff;
    logic          busy;

    assign busy    = (state == WR_AW_W) | (state == WR_B) |
                     (state == RD_AR) | (state == RD_R);
    assign cnt_eff = (state != state_q) ? '0 : cnt;
    assign tmo     = busy & (cnt_eff == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt     <= '0;
        end else begin
            state_q <= state;
            cnt     <= busy ? cnt_eff + 1'b1 : '0;
        end
    end
`else
    assign tmo = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            wr_q            <= 1'b0;
            cmd_ready       <= 1'b1;
            rsp_valid       <= 1'b0;
            rsp_write       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_resp        <= 2'b00;
            rsp_timeout     <= 1'b0;
            axil_if.awaddr  <= '0;
            axil_if.awvalid <= 1'b0;
            axil_if.wdata   <= '0;
            axil_if.wstrb   <= '0;
            axil_if.wvalid  <= 1'b0;
            axil_if.bready  <= 1'b0;
            axil_if.araddr  <= '0;
            axil_if.arvalid <= 1'b0;
            axil_if.rready  <= 1'b0;
        end else if (tmo_fire) begin
            // Debug recovery: abandons the bus, even a valid still waiting on ready.
            axil_if.awvalid <= 1'b0;
            axil_if.wvalid  <= 1'b0;
            axil_if.bready  <= 1'b0;
            axil_if.arvalid <= 1'b0;
            axil_if.rready  <= 1'b0;
            rsp_valid       <= 1'b1;
            rsp_write       <= wr_q;
            rsp_rdata       <= '0;
            rsp_resp        <= 2'b10;
            rsp_timeout     <= 1'b1;
            state           <= RESP;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        wr_q      <= cmd_write;
                        if (cmd_write) begin
                            axil_if.awaddr  <= cmd_addr;
                            axil_if.wdata   <= cmd_wdata;
                            axil_if.wstrb   <= cmd_wstrb;
                            axil_if.awvalid <= 1'b1;
                            axil_if.wvalid  <= 1'b1;
                            state           <= WR_AW_W;
                        end else begin
                            axil_if.araddr  <= cmd_addr;
                            axil_if.arvalid <= 1'b1;
                            state           <= RD_AR;
                        end
                    end
                end
                WR_AW_W: begin
                    if (aw_hs) axil_if.awvalid <= 1'b0;
                    if (w_hs)  axil_if.wvalid  <= 1'b0;
                    if (adv) begin
                        axil_if.bready <= 1'b1;
                        state          <= WR_B;
                    end
                end
                WR_B: begin
                    if (b_hs) begin
                        axil_if.bready <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_write      <= 1'b1;
                        rsp_rdata      <= '0;
                        rsp_resp       <= axil_if.bresp;
                        rsp_timeout    <= 1'b0;
                        state          <= RESP;
                    end
                end
                RD_AR: begin
                    if (ar_hs) begin
                        axil_if.arvalid <= 1'b0;
                        axil_if.rready  <= 1'b1;
                        state           <= RD_R;
                    end
                end
                RD_R: begin
                    if (r_hs) begin
                        axil_if.rready <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_write      <= 1'b0;
                        rsp_rdata      <= axil_if.rdata;
                        rsp_resp       <= axil_if.rresp;
                        rsp_timeout    <= 1'b0;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master against a small AXI-Lite RAM slave model.
// Timeout scenario runs only when AXIL_CMD_MASTER_TIMEOUT_EN is defined.
module tb_axil_cmd_master;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    AXIL_IF #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axil_cmd_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .axil_if(bus)
    );

    // ---------------- slave model ----------------
    int            aw_delay = 0;
    logic [1:0]    bresp_cfg = 2'b00;
    logic          ar_block = 1'b0;
    logic [31:0]   mem [0:255];
    int            aw_cnt;
    logic          aw_got, w_got;
    logic [AW-1:0] aw_a;
    logic [31:0]   w_d;
    logic [3:0]    w_s;
    logic          s_aw_hs, s_w_hs, s_ar_hs;
    logic [AW-1:0] wa;
    logic [31:0]   wd;
    logic [3:0]    ws;

    assign bus.awready = (aw_cnt >= aw_delay);
    assign bus.wready  = 1'b1;
    assign bus.arready = ~ar_block;
    assign s_aw_hs = bus.awvalid & bus.awready;
    assign s_w_hs  = bus.wvalid & bus.wready;
    assign s_ar_hs = bus.arvalid & bus.arready;
    assign wa = s_aw_hs ? bus.awaddr : aw_a;
    assign wd = s_w_hs ? bus.wdata : w_d;
    assign ws = s_w_hs ? bus.wstrb : w_s;

    always @(posedge clk) begin
        if (reset) begin
            aw_cnt     <= 0;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            aw_a       <= '0;
            w_d        <= '0;
            w_s        <= '0;
            bus.bvalid <= 1'b0;
            bus.bresp  <= 2'b00;
            bus.rvalid <= 1'b0;
            bus.rresp  <= 2'b00;
            bus.rdata  <= '0;
        end else begin
            if (bus.awvalid && !bus.awready) aw_cnt <= aw_cnt + 1;
            else aw_cnt <= 0;
            if (s_aw_hs) begin aw_a <= bus.awaddr; aw_got <= 1'b1; end
            if (s_w_hs) begin w_d <= bus.wdata; w_s <= bus.wstrb; w_got <= 1'b1; end
            if ((aw_got || s_aw_hs) && (w_got || s_w_hs) && !bus.bvalid) begin
                for (int i = 0; i < 4; i++)
                    if (ws[i]) mem[wa[9:2]][8*i +: 8] <= wd[8*i +: 8];
                bus.bvalid <= 1'b1;
                bus.bresp  <= bresp_cfg;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
            end
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
            if (s_ar_hs) begin
                bus.rvalid <= 1'b1;
                bus.rdata  <= mem[bus.araddr[9:2]];
                bus.rresp  <= 2'b00;
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
        end
    end

    // ---------------- monitors ----------------
    int cyc = 0;
    int acc_n = 0;
    int acc_q[$];
    int rsp_hi = 0, rsp_pulses = 0;
    logic [31:0] rsp_q[$];
    int aw_hi = 0, w_hi = 0, b_n = 0, aw_unstable = 0;
    logic prev_rsp = 1'b0, prev_aw = 1'b0;
    logic [AW-1:0] prev_awaddr = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && cmd_valid && cmd_ready) begin
            acc_n <= acc_n + 1;
            acc_q.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_hi <= rsp_hi + 1;
            if (!prev_rsp) begin
                rsp_pulses <= rsp_pulses + 1;
                rsp_q.push_back(rsp_rdata);
            end
        end
        if (bus.awvalid) aw_hi <= aw_hi + 1;
        if (bus.wvalid) w_hi <= w_hi + 1;
        if (bus.bvalid && bus.bready) b_n <= b_n + 1;
        if (bus.awvalid && prev_aw && bus.awaddr != prev_awaddr)
            aw_unstable <= aw_unstable + 1;
        prev_rsp    <= rsp_valid;
        prev_aw     <= bus.awvalid;
        prev_awaddr <= bus.awaddr;
    end

    // ---------------- driver ----------------
    task automatic run_cmd(
        input  logic          w,
        input  logic [AW-1:0] a,
        input  logic [31:0]   d,
        input  logic [3:0]    s,
        output logic          got,
        output int            lat,
        output logic [31:0]   rd,
        output logic [1:0]    rr,
        output logic          rw,
        output logic          rt,
        output logic          one
    );
        int n;
        int a0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        a0 = cyc - 1;
        cmd_valid = 1'b0;
        cmd_addr  = '1;
        cmd_wdata = 32'hDEAD_BEEF;
        cmd_wstrb = 4'h0;
        got = 1'b0;
        n = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
            n++;
        end
        lat = cyc - a0;
        rd  = rsp_rdata;
        rr  = rsp_resp;
        rw  = rsp_write;
        rt  = rsp_timeout;
        @(negedge clk);
        one = ~rsp_valid;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_timeout !== 1'b0) begin bad++; $display("FAIL reset_rsp_timeout got=%b exp=0", rsp_timeout); end
        total++; if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
            bad++; $display("FAIL reset_handshakes got=%b exp=00000",
                {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
        end
        total++; if ({bus.awaddr, bus.araddr, bus.wdata} !== '0) begin
            bad++; $display("FAIL reset_addr_data got=%h/%h/%h exp=0", bus.awaddr, bus.araddr, bus.wdata);
        end
        total++; if ({bus.awprot, bus.arprot} !== 6'b0) begin
            bad++; $display("FAIL reset_prot got=%b exp=000000", {bus.awprot, bus.arprot});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic got, rw, rt, one;
        int lat;
        logic [31:0] rd;
        logic [1:0] rr;
        run_cmd(1'b1, 16'd132, 32'd88943, 4'hF, got, lat, rd, rr, rw, rt, one);
        total++; if (got !== 1'b1 || rr !== 2'b00 || rw !== 1'b1) begin bad++; $display("FAIL basic_wr132 got=%b resp=%b write=%b exp=1/00/1", got, rr, rw); end
        total++; if (lat != 3) begin bad++; $display("FAIL basic_wr_latency got=%0d exp=3", lat); end
        total++; if (one !== 1'b1) begin bad++; $display("FAIL basic_wr_pulse got=%b exp=1", one); end
        run_cmd(1'b1, 16'd78, 32'd1332, 4'hF, got, lat, rd, rr, rw, rt, one);
        total++; if (got !== 1'b1 || rr !== 2'b00) begin bad++; $display("FAIL basic_wr78 got=%b resp=%b exp=1/00", got, rr); end
        run_cmd(1'b0, 16'd132, 32'd0, 4'h0, got, lat, rd, rr, rw, rt, one);
        total++; if (rd !== 32'd88943 || rr !== 2'b00 || rw !== 1'b0) begin bad++; $display("FAIL basic_rd132 got=%0d resp=%b write=%b exp=88943/00/0", rd, rr, rw); end
        total++; if (lat != 3 || one !== 1'b1) begin bad++; $display("FAIL basic_rd_timing got=%0d/%b exp=3/1", lat, one); end
        run_cmd(1'b0, 16'd78, 32'd0, 4'h0, got, lat, rd, rr, rw, rt, one);
        total++; if (rd !== 32'd1332 || rr !== 2'b00 || one !== 1'b1) begin bad++; $display("FAIL basic_rd78 got=%0d resp=%b pulse=%b exp=1332/00/1", rd, rr, one); end
    endtask

    task automatic test_strobe();
        logic got, rw, rt, one;
        int lat;
        logic [31:0] rd;
        logic [1:0] rr;
        run_cmd(1'b1, 16'h0010, 32'hAABBCCDD, 4'hF, got, lat, rd, rr, rw, rt, one);
        run_cmd(1'b1, 16'h0010, 32'h11223344, 4'b0011, got, lat, rd, rr, rw, rt, one);
        run_cmd(1'b0, 16'h0010, 32'h0, 4'h0, got, lat, rd, rr, rw, rt, one);
        total++; if (rd !== 32'hAABB3344) begin bad++; $display("FAIL strobe_rd got=%h exp=aabb3344", rd); end
    endtask

    task automatic test_aw_late();
        logic got, rw, rt, one;
        int lat;
        logic [31:0] rd;
        logic [1:0] rr;
        int aw0, w0, b0, u0, p0;
        aw0 = aw_hi; w0 = w_hi; b0 = b_n; u0 = aw_unstable; p0 = rsp_pulses;
        aw_delay = 2;
        run_cmd(1'b1, 16'h0020, 32'h00005A5A, 4'hF, got, lat, rd, rr, rw, rt, one);
        aw_delay = 0;
        total++; if (aw_hi - aw0 != 3) begin bad++; $display("FAIL awlate_aw_cycles got=%0d exp=3", aw_hi - aw0); end
        total++; if (w_hi - w0 != 1) begin bad++; $display("FAIL awlate_w_cycles got=%0d exp=1", w_hi - w0); end
        total++; if (aw_unstable != u0) begin bad++; $display("FAIL awlate_awaddr_stable got=%0d exp=%0d", aw_unstable, u0); end
        total++; if (b_n - b0 != 1) begin bad++; $display("FAIL awlate_b_count got=%0d exp=1", b_n - b0); end
        total++; if (rsp_pulses - p0 != 1 || lat != 5) begin bad++; $display("FAIL awlate_rsp got=%0d lat=%0d exp=1 lat=5", rsp_pulses - p0, lat); end
        run_cmd(1'b0, 16'h0020, 32'h0, 4'h0, got, lat, rd, rr, rw, rt, one);
        total++; if (rd !== 32'h00005A5A) begin bad++; $display("FAIL awlate_readback got=%h exp=00005a5a", rd); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [4];
        logic [31:0]   exp_d [4];
        int a0, p0, h0, q0, k0, idx, n;
        addrs[0] = 16'd132;   exp_d[0] = 32'd88943;
        addrs[1] = 16'd78;    exp_d[1] = 32'd1332;
        addrs[2] = 16'h0010;  exp_d[2] = 32'hAABB3344;
        addrs[3] = 16'h0020;  exp_d[3] = 32'h00005A5A;
        a0 = acc_n; p0 = rsp_pulses; h0 = rsp_hi; q0 = rsp_q.size(); k0 = acc_q.size();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = addrs[0];
        idx = 0;
        n = 0;
        while (idx < 4 && n < 200) begin
            @(posedge clk);
            #1;
            if (acc_n - a0 > idx) begin
                idx++;
                if (idx < 4) cmd_addr = addrs[idx];
                else cmd_valid = 1'b0;
            end
            n++;
        end
        cmd_valid = 1'b0;
        n = 0;
        while (rsp_pulses - p0 < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        total++; if (acc_n - a0 != 4) begin bad++; $display("FAIL b2b_accepts got=%0d exp=4", acc_n - a0); end
        total++; if (rsp_pulses - p0 != 4 || rsp_hi - h0 != 4) begin
            bad++; $display("FAIL b2b_pulses got=%0d high=%0d exp=4/4", rsp_pulses - p0, rsp_hi - h0);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q0 + k >= rsp_q.size()) begin
                bad++; $display("FAIL b2b_order_%0d got=missing exp=%h", k, exp_d[k]);
            end else if (rsp_q[q0 + k] !== exp_d[k]) begin
                bad++; $display("FAIL b2b_order_%0d got=%h exp=%h", k, rsp_q[q0 + k], exp_d[k]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (k0 + k + 1 >= acc_q.size()) begin
                bad++; $display("FAIL b2b_spacing_%0d got=missing exp=4", k);
            end else if (acc_q[k0 + k + 1] - acc_q[k0 + k] != 4) begin
                bad++; $display("FAIL b2b_spacing_%0d got=%0d exp=4", k, acc_q[k0 + k + 1] - acc_q[k0 + k]);
            end
        end
    endtask

    task automatic test_bresp_err();
        logic got, rw, rt, one;
        int lat;
        logic [31:0] rd;
        logic [1:0] rr;
        bresp_cfg = 2'b10;
        run_cmd(1'b1, 16'h0040, 32'h12345678, 4'hF, got, lat, rd, rr, rw, rt, one);
        bresp_cfg = 2'b00;
        total++; if (rr !== 2'b10 || rw !== 1'b1 || rt !== 1'b0) begin
            bad++; $display("FAIL bresp_err got=%b/%b/%b exp=10/1/0", rr, rw, rt);
        end
    endtask

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        logic got, rw, rt, one;
        int lat;
        logic [31:0] rd;
        logic [1:0] rr;
        ar_block = 1'b1;
        run_cmd(1'b0, 16'h0010, 32'h0, 4'h0, got, lat, rd, rr, rw, rt, one);
        ar_block = 1'b0;
        total++; if (got !== 1'b1 || lat != TO + 1) begin bad++; $display("FAIL timeout_latency got=%b/%0d exp=1/%0d", got, lat, TO + 1); end
        total++; if (rt !== 1'b1 || rr !== 2'b10 || rd !== 32'h0) begin
            bad++; $display("FAIL timeout_fields got=%b/%b/%h exp=1/10/0", rt, rr, rd);
        end
        run_cmd(1'b0, 16'h0010, 32'h0, 4'h0, got, lat, rd, rr, rw, rt, one);
        total++; if (rd !== 32'hAABB3344 || rt !== 1'b0 || rr !== 2'b00) begin
            bad++; $display("FAIL timeout_recover got=%h/%b/%b exp=aabb3344/0/00", rd, rt, rr);
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic got, rw, rt, one;
        int lat;
        logic [31:0] rd;
        logic [1:0] rr;
        int n;
        aw_delay = 50;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 16'h0080;
        cmd_wdata = 32'hCAFE0001;
        cmd_wstrb = 4'hF;
        n = 0;
        while (!bus.awvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        total++; if (bus.awvalid !== 1'b1) begin bad++; $display("FAIL rstmid_started got=%b exp=1", bus.awvalid); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++; if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
            bad++; $display("FAIL rstmid_valids got=%b exp=00000",
                {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
        end
        total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_cmd got=%b/%b exp=1/0", cmd_ready, rsp_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        aw_delay = 0;
        run_cmd(1'b0, 16'd132, 32'h0, 4'h0, got, lat, rd, rr, rw, rt, one);
        total++; if (rd !== 32'd88943 || got !== 1'b1) begin bad++; $display("FAIL rstmid_recover got=%0d/%b exp=88943/1", rd, got); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_aw_late();
        test_back_to_back();
        test_bresp_err();
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
